// File: rtl/riscv_definitions.sv
// riscv_definitions: shared ALU/muldiv opcode enums, muldiv FSM states and op-class helpers
package riscv_definitions;
  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
  } alu_ops_t;
  typedef enum logic [2:0] {
    MD_MUL, MD_MULH, MD_MULHSU, MD_MULHU, MD_DIV, MD_DIVU, MD_REM, MD_REMU
  } md_ops_t;
  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} md_state_t;
  function automatic logic md_is_div(input md_ops_t op);
    return op inside {MD_DIV, MD_DIVU, MD_REM, MD_REMU};
  endfunction
  function automatic logic md_is_rem(input md_ops_t op);
    return op inside {MD_REM, MD_REMU};
  endfunction
endpackage

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative shift-add multiplier / restoring divider, one bit per cycle
// Optional MULDIV_EARLY_OUT_EN: trivial cases (div by zero, signed overflow, zero mul operand) skip CALC
module muldiv_unit
  import riscv_definitions::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] operand_a,
  input  logic [XLEN-1:0] operand_b,
  input  md_ops_t         md_op,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            busy
);
  localparam int CW = $clog2(XLEN);
  md_state_t         state;
  md_ops_t           op;
  logic [CW-1:0]     cnt;
  logic [2*XLEN-1:0] acc;
  logic [XLEN-1:0]   a_raw, b_mag, res;
  logic              neg_q, neg_r, b_zero, special, zero_r;
  logic              a_sgn_in, b_sgn_in, ovf_in, special_in;
  logic [XLEN-1:0]   a_mag_in, b_mag_in;
  logic [XLEN:0]     mul_sum, rem_sh, diff;
  logic [2*XLEN-1:0] step_nxt, prod;
  logic [XLEN-1:0]   quo, rmd, spc_val, norm_val, fix_res;
  always_comb begin
    a_sgn_in   = (md_op inside {MD_MULH, MD_MULHSU, MD_DIV, MD_REM}) && operand_a[XLEN-1];
    b_sgn_in   = (md_op inside {MD_MULH, MD_DIV, MD_REM}) && operand_b[XLEN-1];
    a_mag_in   = a_sgn_in ? -operand_a : operand_a;
    b_mag_in   = b_sgn_in ? -operand_b : operand_b;
    ovf_in     = (md_op inside {MD_DIV, MD_REM}) && operand_a == {1'b1, {(XLEN-1){1'b0}}} && &operand_b;
    special_in = md_is_div(md_op) ? (operand_b == '0 || ovf_in) : (operand_a == '0 || operand_b == '0);
  end
  // acc holds {partial product | remainder, multiplier | dividend-shifting-into-quotient}
  always_comb begin
    mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, b_mag} : '0);
    rem_sh   = acc[2*XLEN-1:XLEN-1];
    diff     = rem_sh - {1'b0, b_mag};
    step_nxt = md_is_div(op) ? {diff[XLEN] ? rem_sh[XLEN-1:0] : diff[XLEN-1:0], acc[XLEN-2:0], ~diff[XLEN]}
                             : {mul_sum, acc[XLEN-1:1]};
  end
  always_comb begin
    prod     = neg_q ? -acc : acc;
    quo      = neg_q ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    rmd      = neg_r ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
    norm_val = md_is_rem(op) ? rmd : md_is_div(op) ? quo : op == MD_MUL ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    spc_val  = !md_is_div(op) ? '0 :
               b_zero ? (md_is_rem(op) ? a_raw : '1) :
               (md_is_rem(op) ? '0 : a_raw);
    fix_res  = special ? spc_val : norm_val;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      op      <= MD_MUL;
      cnt     <= '0;
      acc     <= '0;
      a_raw   <= '0;
      b_mag   <= '0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      b_zero  <= 1'b0;
      special <= 1'b0;
      res     <= '0;
      zero_r  <= 1'b0;
    end else if (state == S_IDLE) begin
      if (in_valid) begin
        op      <= md_op;
        cnt     <= CW'(XLEN-1);
        acc     <= {{XLEN{1'b0}}, a_mag_in};
        a_raw   <= operand_a;
        b_mag   <= b_mag_in;
        neg_q   <= a_sgn_in ^ b_sgn_in;
        neg_r   <= a_sgn_in;
        b_zero  <= operand_b == '0;
        special <= special_in;
`ifdef MULDIV_EARLY_OUT_EN
        state   <= special_in ? S_FIX : S_CALC;
`else
        state   <= S_CALC;
`endif
      end
    end else if (flush) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else if (state == S_CALC) begin
      acc <= step_nxt;
      cnt <= cnt - 1'b1;
      if (cnt == '0) state <= S_FIX;
    end else if (state == S_FIX) begin
      res    <= fix_res;
      zero_r <= fix_res == '0;
      state  <= S_DONE;
    end else if (out_ready) begin
      state <= S_IDLE;
    end
  end
  assign in_ready  = state == S_IDLE;
  assign out_valid = state == S_DONE;
  assign busy      = state != S_IDLE;
  assign result    = res;
  assign zero      = zero_r && state == S_DONE;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed vectors for muldiv_unit (XLEN=32), latency, hold, flush and reset
module tb_muldiv_unit;
  import riscv_definitions::*;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0, flush = 1'b0, out_ready = 1'b0;
  logic [31:0] operand_a = '0, operand_b = '0;
  md_ops_t     md_op = MD_MUL;
  logic        in_ready, out_valid, zero, busy;
  logic [31:0] result;
  int          total = 0, bad = 0;
`ifdef MULDIV_EARLY_OUT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif
  muldiv_unit #(.XLEN(32)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .operand_a(operand_a), .operand_b(operand_b), .md_op(md_op), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .zero(zero), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask
  task automatic run(input string tag, input md_ops_t op, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] exp, input bit spc, input int hold);
    int lat;
    logic [31:0] r0;
    in_valid = 1'b1; md_op = op; operand_a = a; operand_b = b;
    @(posedge clk); #1;
    in_valid = 1'b0; operand_a = $urandom; operand_b = $urandom; md_op = md_ops_t'($urandom_range(0, 7));
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, " lat"}, 64'(lat), (EARLY && spc) ? 64'd2 : 64'd34);
    chk({tag, " res"}, 64'(result), 64'(exp));
    chk({tag, " zero"}, 64'(zero), 64'(exp == 32'd0));
    r0 = result;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk({tag, " hold res"}, 64'(result), 64'(r0));
      chk({tag, " hold rdy"}, 64'({in_ready, out_valid}), 64'b01);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, " idle"}, 64'({in_ready, busy, out_valid}), 64'b100);
  endtask
  task automatic start_mul_to_cycle10;
    in_valid = 1'b1; md_op = MD_MUL; operand_a = 32'd9; operand_b = 32'd9;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
  endtask
  initial begin
    bit seen;
    #12;
    chk("rst outs", 64'({out_valid, busy, zero}), 64'b000);
    chk("rst res", 64'(result), 64'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    #10;
    chk("rst rdy", 64'(in_ready), 64'd1);
    run("mul", MD_MUL, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0, 0);
    run("mulh", MD_MULH, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0, 0);
    run("mulhu", MD_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 0);
    run("mulhsu", MD_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0);
    run("mul0", MD_MUL, 32'd0, 32'd5, 32'd0, 1'b1, 0);
    run("divu0", MD_DIVU, 32'd100, 32'd0, 32'hFFFF_FFFF, 1'b1, 0);
    run("remu0", MD_REMU, 32'd100, 32'd0, 32'd100, 1'b1, 0);
    run("div0", MD_DIV, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF, 1'b1, 0);
    run("rem0", MD_REM, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 1'b1, 0);
    run("divovf", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 0);
    run("removf", MD_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b1, 0);
    run("div-7/2", MD_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0, 0);
    run("rem-7/2", MD_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b0, 0);
    run("div7/-2", MD_DIV, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0, 0);
    run("rem7/-2", MD_REM, 32'd7, 32'hFFFF_FFFE, 32'd1, 1'b0, 0);
    run("divu", MD_DIVU, 32'd100, 32'd7, 32'd14, 1'b0, 0);
    run("remu", MD_REMU, 32'd100, 32'd7, 32'd2, 1'b0, 5);
    start_mul_to_cycle10();
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush st", 64'({busy, out_valid, in_ready}), 64'b001);
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      seen |= out_valid;
    end
    chk("flush nov", 64'(seen), 64'd0);
    run("mul3x5a", MD_MUL, 32'd3, 32'd5, 32'd15, 1'b0, 0);
    start_mul_to_cycle10();
    #2 reset = 1'b0;
    #1;
    chk("arst st", 64'({busy, out_valid, zero}), 64'b000);
    chk("arst res", 64'(result), 64'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      seen |= out_valid;
    end
    chk("arst nov", 64'({seen, in_ready}), 64'b01);
    run("mul3x5b", MD_MUL, 32'd3, 32'd5, 32'd15, 1'b0, 0);
    flush = 1'b1;
    in_valid = 1'b1; md_op = MD_MUL; operand_a = 32'd2; operand_b = 32'd2;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    chk("idle flush", 64'(busy), 64'd1);
    repeat (40) @(posedge clk);
    #1;
    chk("idle fl res", 64'({out_valid, result}), {31'd0, 1'b1, 32'd4});
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32: operand and result width; legal values 8..64.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have port in_valid, input, 1: request present.
REQ-005 SHALL have port in_ready, output, 1: unit can accept a request.
REQ-006 SHALL have ports operand_a and operand_b, input, XLEN: rs1 and rs2 values.
REQ-007 SHALL have port md_op, input, md_ops_t: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM or REMU.
REQ-008 SHALL have port flush, input, 1: abort the in-flight operation.
REQ-009 SHALL have port out_valid, output, 1: result present.
REQ-010 SHALL have port out_ready, input, 1: consumer accepts the result.
REQ-011 SHALL have port result, output, XLEN: operation result.
REQ-012 SHALL have port zero, output, 1: result equals 0, qualified by out_valid.
REQ-013 SHALL have port busy, output, 1: state is not IDLE.

Function
REQ-014 SHALL implement FSM states IDLE, CALC, FIX and DONE.
REQ-015 SHALL drive in_ready=1 only in IDLE; acceptance is in_valid&&in_ready at a clock edge, which latches the operands and md_op.
REQ-016 SHALL on acceptance go IDLE->CALC and load iteration counter with XLEN-1.
REQ-017 SHALL perform one shift-add multiply or restoring-divide step per CALC cycle on magnitudes, using a 2*XLEN-bit product/remainder register.
REQ-018 SHALL go CALC->FIX when counter is 0; FIX applies sign correction and selects the low/high product, quotient or remainder; then FIX->DONE.
REQ-019 SHALL assert out_valid only in DONE, XLEN+2 cycles after acceptance (34 for XLEN=32); result and zero SHALL be held stable until out_ready.
REQ-020 SHALL go DONE->IDLE on out_ready=1; the next request can be accepted one cycle later, giving a throughput of 1 per XLEN+3 cycles.
REQ-021 SHALL for divide by zero return quotient all-ones (DIV/DIVU) and remainder = operand_a (REM/REMU).
REQ-022 SHALL for signed overflow (DIV/REM of most-negative by -1) return quotient = most-negative and remainder = 0.
REQ-023 SHALL for MULHSU treat operand_a as signed and operand_b as unsigned.
REQ-024 SHALL on flush=1 in CALC, FIX or DONE return to IDLE next cycle without asserting out_valid; flush SHALL be ignored in IDLE, and flush has priority over out_ready.
REQ-025 SHALL ignore in_valid while busy; operand changes SHALL not affect an in-flight operation.

Reset
REQ-026 SHALL on reset=0 immediately enter IDLE, including mid-operation, with out_valid=0, result=0, zero=0, busy=0 and counter=0; in_ready=1 after release.

Configuration
REQ-027 SHALL with MULDIV_EARLY_OUT_EN defined complete divide by zero, signed overflow, and multiplies with any zero operand via IDLE->FIX->DONE, with out_valid 2 cycles after acceptance.
REQ-028 SHALL without MULDIV_EARLY_OUT_EN take XLEN+2 cycles for all operations; results SHALL be bit-identical in both builds.

Structure
REQ-029 SHALL place md_ops_t and the FSM state enum in shared package riscv_definitions, alongside alu_ops_t.
REQ-030 SHALL contain no sub-module; the shift-add/subtract datapath SHALL be inline.

Verification (XLEN=32, macro off unless stated)
REQ-031 SHALL cover MUL 7 x 0xFFFFFFFD -> result 0xFFFFFFEB, out_valid exactly 34 cycles after acceptance; MULH 0x80000000 x 0x80000000 -> 0x40000000.
REQ-032 SHALL cover DIVU 100/0 -> 0xFFFFFFFF and REMU 100/0 -> 100; DIV 0x80000000/0xFFFFFFFF -> 0x80000000 and REM -> 0, zero=1.
REQ-033 SHALL cover DIV 0xFFFFFFF9 (-7) / 2 -> 0xFFFFFFFD and REM -> 0xFFFFFFFF; MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
REQ-034 SHALL cover out_ready held low 5 cycles in DONE -> result stable and in_ready=0 throughout, then IDLE one cycle after out_ready.
REQ-035 SHALL cover flush at cycle 10 of CALC, and separately reset=0 at cycle 10 -> no out_valid, busy=0, and a new MUL 3 x 5 -> 15 completes correctly.
REQ-036 SHALL cover, with MULDIV_EARLY_OUT_EN defined, DIVU 5/0 -> out_valid 2 cycles after acceptance, result 0xFFFFFFFF.
